// File: rtl/dca_matrix_mreg2store_pkg.sv
// dca_matrix_mreg2store_pkg
//   Shared types and dimension helpers for the mreg-to-store row drain.
//   - state_t           : FSM encoding (2-bit), also exposed on dbg_state
//   - matrix_dim()      : matrix size selector -> rows/cols (square matrix)
//   - tensor_scalar_bw(): tensor format selector -> scalar width in bits
//   - norm_limit()      : 0 or out-of-range limits mean "full dimension"
package dca_matrix_mreg2store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int matrix_dim(input int size_para);
        return size_para;
    endfunction

    function automatic int tensor_scalar_bw(input int tensor_para);
        case (tensor_para)
            1:       return 16;
            2:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned norm_limit(input int unsigned value,
                                               input int unsigned max_value);
        if ((value == 0) || (value > max_value)) return max_value;
        return value;
    endfunction

endpackage

// File: rtl/dca_matrix_mreg2store_counter.sv
// dca_matrix_mreg2store_counter
//   Row counter kept in one-hot form so that "counter == N" is a plain
//   vector compare against a one-hot constant.
//   Ports:
//   - clk, rstnn   : clock, async active-low reset
//   - init         : force the count back to row 0 (wins over count)
//   - count        : advance by one row, wrapping after COUNT_LENGTH-1
//   - value_onehot : current row, one-hot
module dca_matrix_mreg2store_counter #(
    parameter int COUNT_LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    init,
    input  logic                    count,
    output logic [COUNT_LENGTH-1:0] value_onehot
);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            value_onehot <= COUNT_LENGTH'(1);
        end else if (init) begin
            value_onehot <= COUNT_LENGTH'(1);
        end else if (count) begin
            value_onehot <= {value_onehot[COUNT_LENGTH-2:0], value_onehot[COUNT_LENGTH-1]};
        end
    end

endmodule

// File: rtl/dca_matrix_mreg2store.sv
// dca_matrix_mreg2store
//   Drains the matrix register (mreg) as a stream of tensor rows. Only the
//   requested number of rows is emitted; the remaining padding rows are
//   shifted out of mreg silently so mreg is always empty on return to IDLE.
//   Ports:
//   - clk, rstnn, clear, enable      : clock, async reset, sync abort, advance qualifier
//   - busy, storereg_wready          : status / accept-matrix indication
//   - storereg_wrequest              : start a transfer (limits sampled here)
//   - num_valid_row, num_valid_col   : row / column limits (0 or too big = full)
//   - mreg_move_renable              : shift mreg up one row
//   - mreg_move_rdata_list1d         : head row of mreg
//   - store_tensor_row_w*            : outbound row channel
//   - dbg_state                      : current FSM state
//
// Row channel: a row transfers in every cycle where wvalid and wready are
// both high. wdata/wlast depend only on mreg's head row and the row counter,
// and neither moves without a transfer, so they stay stable while wvalid is
// held against a low wready. wvalid itself follows enable (enable low stalls).
module dca_matrix_mreg2store
    import dca_matrix_mreg2store_pkg::*;
#(
    parameter  int MATRIX_SIZE_PARA = 4,
    parameter  int TENSOR_PARA      = 0,
    localparam int MATRIX_NUM_ROW   = matrix_dim(MATRIX_SIZE_PARA),
    localparam int MATRIX_NUM_COL   = matrix_dim(MATRIX_SIZE_PARA),
    localparam int BW_TENSOR_SCALAR = tensor_scalar_bw(TENSOR_PARA),
    localparam int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
    localparam int BW_ROW_COUNT     = $clog2(MATRIX_NUM_ROW + 1),
    localparam int BW_COL_COUNT     = $clog2(MATRIX_NUM_COL + 1)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    output logic                     storereg_wready,
    input  logic                     storereg_wrequest,
    input  logic [BW_ROW_COUNT-1:0]  num_valid_row,
    input  logic [BW_COL_COUNT-1:0]  num_valid_col,
    output logic                     mreg_move_renable,
    input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
    output logic                     store_tensor_row_wvalid,
    output logic                     store_tensor_row_wlast,
    output logic [BW_TENSOR_ROW-1:0] store_tensor_row_wdata,
    input  logic                     store_tensor_row_wready,
    output logic [1:0]               dbg_state
);

    localparam logic [BW_TENSOR_SCALAR-1:0] TENSOR_ZERO = '0;

    state_t                    state;
    logic [MATRIX_NUM_ROW-1:0] row_onehot;
    logic [MATRIX_NUM_ROW-1:0] last_row_onehot;   // one-hot of (row limit - 1)
    logic [BW_COL_COUNT-1:0]   col_limit;

    logic                      start;
    logic                      handshake;
    logic                      drain_step;
    logic [BW_ROW_COUNT-1:0]   row_limit_norm;
    logic [BW_COL_COUNT-1:0]   col_limit_norm;
    logic [MATRIX_NUM_ROW-1:0] start_last_onehot;

    assign row_limit_norm    = BW_ROW_COUNT'(norm_limit(32'(num_valid_row), MATRIX_NUM_ROW));
    assign col_limit_norm    = BW_COL_COUNT'(norm_limit(32'(num_valid_col), MATRIX_NUM_COL));
    assign start_last_onehot = MATRIX_NUM_ROW'(1) << (row_limit_norm - BW_ROW_COUNT'(1));

    assign start      = (state == ST_IDLE) & enable & storereg_wrequest & ~clear;
    assign handshake  = store_tensor_row_wvalid & store_tensor_row_wready;
    assign drain_step = (state == ST_DRAIN) & enable & ~clear;

    // clear suppresses both the row offer and the mreg shift in its cycle.
    assign store_tensor_row_wvalid = (state == ST_SEND) & enable & ~clear;
    assign store_tensor_row_wlast  = (state == ST_SEND) & (row_onehot == last_row_onehot);
    assign mreg_move_renable       = handshake | drain_step;

    assign busy            = (state != ST_IDLE);
    assign storereg_wready = (state == ST_IDLE);
    assign dbg_state       = state;

    for (genvar i = 0; i < MATRIX_NUM_COL; i++) begin : g_col
        assign store_tensor_row_wdata[i*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] =
            (BW_COL_COUNT'(i) < col_limit) ?
                mreg_move_rdata_list1d[i*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] : TENSOR_ZERO;
    end

    dca_matrix_mreg2store_counter #(
        .COUNT_LENGTH (MATRIX_NUM_ROW)
    ) u_row_counter (
        .clk          (clk),
        .rstnn        (rstnn),
        .init         (clear | start),
        .count        (mreg_move_renable),
        .value_onehot (row_onehot)
    );

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state           <= ST_IDLE;
            last_row_onehot <= MATRIX_NUM_ROW'(1) << (MATRIX_NUM_ROW - 1);
            col_limit       <= BW_COL_COUNT'(MATRIX_NUM_COL);
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state           <= ST_SEND;
                        last_row_onehot <= start_last_onehot;
                        col_limit       <= col_limit_norm;
                    end
                end
                ST_SEND: begin
                    // After the last valid row, any rows left in mreg are padding.
                    if (handshake && store_tensor_row_wlast) begin
                        state <= row_onehot[MATRIX_NUM_ROW-1] ? ST_IDLE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_step && row_onehot[MATRIX_NUM_ROW-1]) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
